// File: rtl/lc3_io_pkg.sv
// lc3_io_pkg: shared LC3 I/O constants (UART FSM encoding, UARTSR bit map, addresses, mux select)
package lc3_io_pkg;

   typedef logic [2:0] uart_state_t;

   localparam uart_state_t ST_IDLE   = 3'd0;
   localparam uart_state_t ST_START  = 3'd1;
   localparam uart_state_t ST_DATA   = 3'd2;
   localparam uart_state_t ST_PARITY = 3'd3;
   localparam uart_state_t ST_STOP   = 3'd4;

   localparam int SR_READY = 15;
   localparam int SR_IE    = 14;
   localparam int SR_OVR   = 13;

   localparam logic [15:0] ADDR_UARTSR = 16'h7E14;
   localparam logic [15:0] ADDR_UARTDR = 16'h7E16;

   localparam logic [3:0] INMUX_SEL_UARTSR = 4'b1011;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit cycle counter, pulses bit_done on the last cycle of each serial bit
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic bit_done
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] r_cnt;

   assign bit_done = run && (r_cnt == LAST);

   // count 0..LAST while a frame is running, wrap at each bit boundary, hold at 0 when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= '0;
      else if (!run || bit_done) r_cnt <= '0;
      else r_cnt <= r_cnt + 16'd1;
   end

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped LC3 UART transmitter (UARTDR/UARTSR); define UART_TX_PARITY_EN for an even parity bit
module uart_tx_dev
   import lc3_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] MDR_in,
   input  logic        LD_UARTDR,
   input  logic        LD_UARTSR,
   output logic [15:0] UARTSR_out,
   output logic        uart_txd,
   output logic        uart_irq
);

   uart_state_t r_state;
   logic [7:0]  r_shift;
   logic [2:0]  r_bit;
   logic        r_ready;
   logic        r_ie;
   logic        r_ovr;
`ifdef UART_TX_PARITY_EN
   logic        r_par;
`endif

   logic w_bit_done;
   logic w_load;
   logic w_unused;

   assign w_load   = LD_UARTDR && r_ready;
   assign w_unused = &{1'b0, MDR_in[15], MDR_in[13:8]};

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .run      (r_state != ST_IDLE),
      .bit_done (w_bit_done)
   );

   // frame sequencer: accept a byte when READY, then walk START/DATA[/PARITY]/STOP one bit time each
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_ready <= 1'b1;
      end else if (w_load) begin
         r_state <= ST_START;
         r_shift <= MDR_in[7:0];
         r_bit   <= '0;
         r_ready <= 1'b0;
      end else if (w_bit_done) begin
         case (r_state)
            ST_START: r_state <= ST_DATA;
            ST_DATA: begin
               r_shift <= r_shift >> 1;
               r_bit   <= r_bit + 3'd1;
`ifdef UART_TX_PARITY_EN
               if (r_bit == 3'd7) r_state <= ST_PARITY;
`else
               if (r_bit == 3'd7) r_state <= ST_STOP;
`endif
            end
            ST_PARITY: r_state <= ST_STOP;
            ST_STOP: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef UART_TX_PARITY_EN
   // even parity of the accepted byte, fixed for the whole frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_par <= 1'b0;
      else if (w_load) r_par <= ^MDR_in[7:0];
   end
`endif

   // status bits: IE is software-written; an overrun set beats a same-cycle clear from a status write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ie  <= 1'b0;
         r_ovr <= 1'b0;
      end else begin
         if (LD_UARTSR) r_ie <= MDR_in[SR_IE];
         if (LD_UARTDR && !r_ready) r_ovr <= 1'b1;
         else if (LD_UARTSR) r_ovr <= 1'b0;
      end
   end

   // line level and status read value decoded from registered state
   always_comb begin
      UARTSR_out           = '0;
      UARTSR_out[SR_READY] = r_ready;
      UARTSR_out[SR_IE]    = r_ie;
      UARTSR_out[SR_OVR]   = r_ovr;
      uart_irq             = r_ready & r_ie;
`ifdef UART_TX_PARITY_EN
      uart_txd = (r_state == ST_START)  ? 1'b0 :
                 (r_state == ST_DATA)   ? r_shift[0] :
                 (r_state == ST_PARITY) ? r_par : 1'b1;
`else
      uart_txd = (r_state == ST_START) ? 1'b0 :
                 (r_state == ST_DATA)  ? r_shift[0] : 1'b1;
`endif
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed self-checking bench for uart_tx_dev at CLKS_PER_BIT=4 (honours UART_TX_PARITY_EN)
module tb_uart_tx_dev;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] MDR_in;
   logic        LD_UARTDR;
   logic        LD_UARTSR;
   logic [15:0] UARTSR_out;
   logic        uart_txd;
   logic        uart_irq;

   int checks = 0;
   int errors = 0;

   uart_tx_dev #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .MDR_in     (MDR_in),
      .LD_UARTDR  (LD_UARTDR),
      .LD_UARTSR  (LD_UARTSR),
      .UARTSR_out (UARTSR_out),
      .uart_txd   (uart_txd),
      .uart_irq   (uart_irq)
   );

   always #5 clk = ~clk;

   function automatic logic exp_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic dr_write(input logic [15:0] d);
      MDR_in = d;
      LD_UARTDR = 1'b1;
      @(negedge clk);
      LD_UARTDR = 1'b0;
      MDR_in = '0;
   endtask

   task automatic sr_write(input logic [15:0] d);
      MDR_in = d;
      LD_UARTSR = 1'b1;
      @(negedge clk);
      LD_UARTSR = 1'b0;
      MDR_in = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      MDR_in = '0;
      LD_UARTDR = 1'b0;
      LD_UARTSR = 1'b0;
      #1;
      checks++;
      if (UARTSR_out !== 16'h8000) begin errors++; $display("FAIL reset_sr got %h want 8000", UARTSR_out); end
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", uart_txd); end
      checks++;
      if (uart_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", uart_irq); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_byte;
      int bad = 0;
      int rdy_bad = 0;
      dr_write(16'hAB55);
      for (int i = 0; i < FL; i++) begin
         if (uart_txd !== exp_bit(8'h55, i / CPB)) bad++;
         if (UARTSR_out[15] !== 1'b0) rdy_bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL single_txd wrong_cycles %0d want 0", bad); end
      checks++;
      if (rdy_bad != 0) begin errors++; $display("FAIL single_ready_low ready_high_cycles %0d want 0", rdy_bad); end
      checks++;
      if (UARTSR_out !== 16'h8000) begin errors++; $display("FAIL single_sr_end got %h want 8000", UARTSR_out); end
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL single_idle_txd got %b want 1", uart_txd); end
   endtask

   task automatic test_overrun;
      int bad = 0;
      dr_write(16'h003C);
      for (int i = 0; i < FL; i++) begin
         if (uart_txd !== exp_bit(8'h3C, i / CPB)) bad++;
         if (i == 6) begin
            checks++;
            if (UARTSR_out !== 16'h2000) begin errors++; $display("FAIL ovr_set got %h want 2000", UARTSR_out); end
         end
         if (i == 13) begin
            checks++;
            if (UARTSR_out !== 16'h0000) begin errors++; $display("FAIL ovr_clear got %h want 0000", UARTSR_out); end
         end
         LD_UARTDR = (i == 5);
         LD_UARTSR = (i == 12);
         MDR_in = (i == 5) ? 16'h000F : 16'h0000;
         @(negedge clk);
      end
      LD_UARTDR = 1'b0;
      LD_UARTSR = 1'b0;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ovr_frame wrong_cycles %0d want 0", bad); end
      checks++;
      if (UARTSR_out !== 16'h8000) begin errors++; $display("FAIL ovr_sr_end got %h want 8000", UARTSR_out); end
      @(negedge clk);
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL ovr_no_second_frame got %b want 1", uart_txd); end
   endtask

   task automatic test_interrupt;
      int irq_bad = 0;
      sr_write(16'h4000);
      checks++;
      if (UARTSR_out !== 16'hC000) begin errors++; $display("FAIL irq_sr got %h want C000", UARTSR_out); end
      checks++;
      if (uart_irq !== 1'b1) begin errors++; $display("FAIL irq_idle got %b want 1", uart_irq); end
      dr_write(16'h0081);
      for (int i = 0; i < FL; i++) begin
         if (uart_irq !== 1'b0) irq_bad++;
         @(negedge clk);
      end
      checks++;
      if (irq_bad != 0) begin errors++; $display("FAIL irq_busy high_cycles %0d want 0", irq_bad); end
      checks++;
      if (uart_irq !== 1'b1) begin errors++; $display("FAIL irq_after_stop got %b want 1", uart_irq); end
      sr_write(16'h0000);
      checks++;
      if (uart_irq !== 1'b0) begin errors++; $display("FAIL irq_disable got %b want 0", uart_irq); end
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      int high_run = 0;
      logic e;
      dr_write(16'h0000);
      for (int i = 0; i < 2 * FL + 1; i++) begin
         e = (i < FL) ? exp_bit(8'h00, i / CPB) : (i == FL) ? 1'b1 : exp_bit(8'hFF, (i - FL - 1) / CPB);
         if (uart_txd !== e) bad++;
         if (i >= FL - CPB && i <= FL && uart_txd === 1'b1) high_run++;
         if (i == FL) begin
            checks++;
            if (UARTSR_out[15] !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", UARTSR_out[15]); end
         end
         if (i == FL + 1) begin
            checks++;
            if (uart_txd !== 1'b0 || UARTSR_out[15] !== 1'b0) begin
               errors++; $display("FAIL b2b_start txd %b ready %b want 0 0", uart_txd, UARTSR_out[15]);
            end
         end
         LD_UARTDR = (i == FL);
         MDR_in = (i == FL) ? 16'h00FF : 16'h0000;
         @(negedge clk);
      end
      LD_UARTDR = 1'b0;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_txd wrong_cycles %0d want 0", bad); end
      checks++;
      if (high_run != CPB + 1) begin errors++; $display("FAIL b2b_gap high_cycles %0d want %0d", high_run, CPB + 1); end
      checks++;
      if (UARTSR_out !== 16'h8000) begin errors++; $display("FAIL b2b_sr_end got %h want 8000", UARTSR_out); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      int par_bad = 0;
      dr_write(16'h0007);
      for (int i = 0; i < 44; i++) begin
         if (i >= 36 && i < 40 && uart_txd !== 1'b1) par_bad++;
         if (i == 43) begin
            checks++;
            if (UARTSR_out[15] !== 1'b0) begin errors++; $display("FAIL par_ready_early got %b want 0", UARTSR_out[15]); end
         end
         @(negedge clk);
      end
      checks++;
      if (par_bad != 0) begin errors++; $display("FAIL par_bit wrong_cycles %0d want 0", par_bad); end
      checks++;
      if (UARTSR_out !== 16'h8000) begin errors++; $display("FAIL par_len got %h want 8000", UARTSR_out); end
   endtask
`endif

   task automatic test_reset_mid_frame;
      int lows = 0;
      sr_write(16'h4000);
      dr_write(16'h0000);
      for (int i = 0; i < 10; i++) begin
         LD_UARTDR = (i == 3);
         @(negedge clk);
      end
      LD_UARTDR = 1'b0;
      checks++;
      if (UARTSR_out !== 16'h6000 || uart_txd !== 1'b0) begin
         errors++; $display("FAIL midrst_pre sr %h txd %b want 6000 0", UARTSR_out, uart_txd);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (UARTSR_out !== 16'h8000) begin errors++; $display("FAIL midrst_sr got %h want 8000", UARTSR_out); end
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL midrst_txd got %b want 1", uart_txd); end
      checks++;
      if (uart_irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b want 0", uart_irq); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < FL; i++) begin
         if (uart_txd !== 1'b1) lows++;
         @(negedge clk);
      end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL midrst_resume low_cycles %0d want 0", lows); end
      checks++;
      if (UARTSR_out !== 16'h8000) begin errors++; $display("FAIL midrst_sr_end got %h want 8000", UARTSR_out); end
   endtask

   initial begin
      test_reset;
      test_single_byte;
      test_overrun;
      test_interrupt;
      test_back_to_back;
`ifdef UART_TX_PARITY_EN
      test_parity;
`endif
      test_reset_mid_frame;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
